seri_mul_arb: RTL and testbench
===============================

# seri_mul_arb

Round-robin arbiter and sequencer that shares one 8-bit serial multiplier (`seri_mul`) among `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time and drives the multiplier's start/operand interface. It captures the product on the done pulse and returns it on a shared response bus tagged with the requester index. It sits between client logic and the single multiplier instance at the top level.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of the requester index, equal to $clog2(N_REQ).
- `TMO`, default 15: cycles allowed in WAIT before a timeout error is declared.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset. The top level drives the multiplier's `rstn` with `~rst`, so both reset together.
- `req_valid` input, N_REQ bits: request pending, one bit per requester.
- `req_a` input, N_REQ*8 bits: operand A. Requester i uses bits [8i+7:8i].
- `req_b` input, N_REQ*8 bits: operand B, same packing as `req_a`.
- `req_ready` output, N_REQ bits: one-hot. The handshake completes on a clock edge where `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid` output, 1 bit: one-cycle response strobe. There is no back-pressure.
- `rsp_id` output, ID_W bits: index of the requester that owns the response.
- `rsp_prod` output, 16 bits: product. Forced to 0 when `rsp_err` is high.
- `rsp_err` output, 1 bit: timeout error flag, qualified by `rsp_valid`.
- `busy` output, 1 bit: high in every state other than ARB.
- `mul_en` output, 1 bit: multiplier start.
- `mul_a` output, 8 bits: multiplier operand A.
- `mul_b` output, 8 bits: multiplier operand B.
- `mul_product` input, 16 bits: multiplier result.
- `mul_done` input, 1 bit: multiplier done pulse.

## Operation
- The multiplier contract is fixed:
  - The multiplier samples `mul_a`/`mul_b` on every edge while idle and starts on an edge where `mul_en=1`.
  - `mul_done` rises 9 edges after the start edge, stays high for exactly one cycle, and `mul_product` is valid in that same cycle.
  - The multiplier becomes idle again on the edge that samples `mul_done`.
- The state machine has four states: ARB, ISSUE, WAIT, RESP.
- ARB:
  - If any `req_valid` bit is set, the grant is the first set bit searching upward from `last+1`, modulo N_REQ. `req_ready[grant]` is asserted combinationally in this cycle.
  - On the edge, latch the grant's operands and index, set `last=grant`, and go to ISSUE.
  - If no `req_valid` bit is set, stay in ARB with `req_ready=0`.
- ISSUE: drive `mul_en=1` with the latched operands for exactly one cycle, clear the timeout counter, and go to WAIT.
- WAIT:
  - `mul_en=0`. `mul_a`/`mul_b` keep holding the latched operands.
  - If `mul_done=1`, latch `mul_product`, set err=0, and go to RESP.
  - Otherwise, if the counter equals `TMO-1`, set err=1 and go to RESP. If not, increment the counter.
- RESP: drive `rsp_valid=1` with `rsp_id`, `rsp_prod`, and `rsp_err` for one cycle, then go to ARB.
- `mul_done` is ignored in ARB, ISSUE and RESP.
- A requester may drop `req_valid` before it is granted. A grant is never made without `req_valid` being high in that cycle.
- Operands of 0 still run the full sequence and return `rsp_prod=0`.
- Reset values:
  - State is ARB and `last=N_REQ-1`, so requester 0 wins first after reset.
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_prod`, `rsp_err`, `busy`, `mul_en`, `mul_a` and `mul_b` are all 0.
- Reset mid-operation aborts the operation with no response. The in-flight requester is not re-served automatically.

## Timing
- Let t be the edge that completes the handshake.
  - Multiplier start edge: t+1.
  - `mul_done` sampled: edge t+11.
  - `rsp_valid` high between edges t+11 and t+12.
  - Next grant possible: edge t+12.
- Sustained throughput is one operation per 12 cycles.
- A timeout response appears TMO+1 edges after ISSUE.
- Everything is registered except `req_ready`, which is a combinational function of state, `req_valid` and `last`.
- With all requesters permanently valid and N_REQ=4, the grant order is 0,1,2,3,0,… There are no skips and no repeats.

## Structure
- Package `seri_mul_pkg` holds:
  - the state enum;
  - `MUL_W=8` and `PROD_W=16`;
  - `MUL_LAT=9`, the number of edges from start to done;
  - the default `TMO`.
- Sub-module `rr_arb` is a parameterised round-robin picker. It takes the request vector and the `last` pointer and produces a one-hot grant plus its index. The `last` register is owned by the top FSM.
- The top level contains the FSM, operand and product registers, the timeout counter, and the response registers.

## Test plan
- **Single request:** requester 2 presents a=13, b=11.
  - Expect `req_ready[2]` in the same cycle.
  - Expect `rsp_valid` 11 edges after the handshake with `rsp_id=2`, `rsp_prod=143`, `rsp_err=0`.
- **Corner operands:**
  - a=255, b=255 → `rsp_prod=65025`.
  - a=0, b=200 → `rsp_prod=0`.
  - a=1, b=128 → `rsp_prod=128`.
- **Round-robin fairness:** all four requesters held valid with distinct operands for 48 cycles.
  - Expect grants in the order 0,1,2,3.
  - Expect responses 12 cycles apart with correct products and ids.
- **Late and withdrawn requests:**
  - Requester 3 asserts during WAIT while requester 0 is being served → expect it to be granted at the next ARB.
  - Requester 1 raises then drops `req_valid` while the block is busy → expect no grant for requester 1.
- **Timeout:** multiplier model never pulses `mul_done`.
  - Expect `rsp_valid` with `rsp_err=1` and `rsp_prod=0` TMO+1 edges after ISSUE, then a return to ARB.
- **Reset mid-operation:** assert `rst` for one cycle during WAIT.
  - Expect all outputs 0 and no response.
  - On a new request from requester 1, expect a normal response with correct timing.

Source files
------------

// File: rtl/seri_mul_pkg.sv
// Shared types and constants for the serial-multiplier arbiter slice.
package seri_mul_pkg;

    localparam int MUL_W   = 8;
    localparam int PROD_W  = 16;
    localparam int MUL_LAT = 9;
    localparam int TMO_DEF = 15;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping.
module rr_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld
);

    // Rotating priority search; the first hit blocks all later candidates.
    always_comb begin
        int  idx_v;
        logic hit_v;
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx_v   = 0;
        hit_v   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_v      = (int'(last) + k) % N_REQ;
            hit_v      = ~gnt_vld & req[idx_v];
            gnt[idx_v] = hit_v;
            gnt_id     = hit_v ? ID_W'(idx_v) : gnt_id;
            gnt_vld    = gnt_vld | hit_v;
        end
    end

endmodule

// File: rtl/seri_mul_arb.sv
// Shares one serial multiplier among N_REQ requesters: arbitrate, issue, wait for
// the done pulse (or time out) and return a tagged response.
module seri_mul_arb
    import seri_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int TMO   = TMO_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*MUL_W-1:0] req_a,
    input  logic [N_REQ*MUL_W-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [PROD_W-1:0]      rsp_prod,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_en,
    output logic [MUL_W-1:0]       mul_a,
    output logic [MUL_W-1:0]       mul_b,
    input  logic [PROD_W-1:0]      mul_product,
    input  logic                   mul_done
);

    localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

    arb_state_e          state_r, state_nxt_s;
    logic [ID_W-1:0]     last_r, last_nxt_s;
    logic [ID_W-1:0]     id_r, id_nxt_s;
    logic [MUL_W-1:0]    op_a_r, op_a_nxt_s;
    logic [MUL_W-1:0]    op_b_r, op_b_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                mul_en_r, mul_en_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                rsp_valid_r, rsp_valid_nxt_s;
    logic [ID_W-1:0]     rsp_id_r, rsp_id_nxt_s;
    logic [PROD_W-1:0]   rsp_prod_r, rsp_prod_nxt_s;
    logic                rsp_err_r, rsp_err_nxt_s;

    logic [N_REQ-1:0]    gnt_s;
    logic [ID_W-1:0]     gnt_id_s;
    logic                gnt_vld_s;

    rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arb (
        .req     (req_valid),
        .last    (last_r),
        .gnt     (gnt_s),
        .gnt_id  (gnt_id_s),
        .gnt_vld (gnt_vld_s)
    );

    // Ready is the only combinational output: the grant, shown only while arbitrating.
    always_comb begin
        if (state_r == ST_ARB) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and next-register values; outputs are registered from these.
    always_comb begin
        state_nxt_s     = state_r;
        last_nxt_s      = last_r;
        id_nxt_s        = id_r;
        op_a_nxt_s      = op_a_r;
        op_b_nxt_s      = op_b_r;
        cnt_nxt_s       = cnt_r;
        mul_en_nxt_s    = 1'b0;
        rsp_valid_nxt_s = 1'b0;
        rsp_id_nxt_s    = rsp_id_r;
        rsp_prod_nxt_s  = rsp_prod_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            ST_ARB: begin
                if (gnt_vld_s) begin
                    op_a_nxt_s   = req_a[int'(gnt_id_s)*MUL_W +: MUL_W];
                    op_b_nxt_s   = req_b[int'(gnt_id_s)*MUL_W +: MUL_W];
                    id_nxt_s     = gnt_id_s;
                    last_nxt_s   = gnt_id_s;
                    mul_en_nxt_s = 1'b1;
                    state_nxt_s  = ST_ISSUE;
                end else begin
                    state_nxt_s  = ST_ARB;
                end
            end
            ST_ISSUE: begin
                cnt_nxt_s   = '0;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    rsp_prod_nxt_s  = mul_product;
                    rsp_err_nxt_s   = 1'b0;
                    rsp_id_nxt_s    = id_r;
                    rsp_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_RESP;
                end else if (cnt_r == CNT_W'(TMO - 1)) begin
                    // Product is forced to zero on a timeout response.
                    rsp_prod_nxt_s  = '0;
                    rsp_err_nxt_s   = 1'b1;
                    rsp_id_nxt_s    = id_r;
                    rsp_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_RESP;
                end else begin
                    cnt_nxt_s       = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_ARB;
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_ARB);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ARB;
            last_r      <= ID_W'(N_REQ - 1);
            id_r        <= '0;
            op_a_r      <= '0;
            op_b_r      <= '0;
            cnt_r       <= '0;
            mul_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_prod_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            last_r      <= last_nxt_s;
            id_r        <= id_nxt_s;
            op_a_r      <= op_a_nxt_s;
            op_b_r      <= op_b_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mul_en_r    <= mul_en_nxt_s;
            busy_r      <= busy_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_id_r    <= rsp_id_nxt_s;
            rsp_prod_r  <= rsp_prod_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    assign mul_en    = mul_en_r;
    assign mul_a     = op_a_r;
    assign mul_b     = op_b_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_prod  = rsp_prod_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_seri_mul_arb.sv
// Directed bench for seri_mul_arb with a behavioural serial-multiplier model.
module tb_seri_mul_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_prod;
    logic        rsp_err;
    logic        busy;
    logic        mul_en;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_product;
    logic        mul_done;

    int n_checks = 0;
    int n_errors = 0;

    seri_mul_arb #(
        .N_REQ (4),
        .ID_W  (2),
        .TMO   (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_prod    (rsp_prod),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mul_en      (mul_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_done    (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: done one cycle, 9 edges after the start edge; junk product otherwise.
    logic [7:0] m_a, m_b;
    logic       m_busy;
    int         m_cnt;
    logic       no_done;

    always @(posedge clk) begin
        if (rst) begin
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            mul_done    <= 1'b0;
            mul_product <= 16'hDEAD;
        end else if (!m_busy) begin
            m_a         <= mul_a;
            m_b         <= mul_b;
            mul_done    <= 1'b0;
            mul_product <= 16'hDEAD;
            if (mul_en) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (mul_done) begin
                mul_done    <= 1'b0;
                m_busy      <= 1'b0;
                mul_product <= 16'hDEAD;
            end else if (m_cnt == 8 && !no_done) begin
                mul_done    <= 1'b1;
                mul_product <= 16'(m_a) * 16'(m_b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until rsp_valid is seen; edges = count of edges taken, -1 if the bound expired.
    task automatic wait_rsp(input int max_e, output int edges);
        int i;
        i     = 0;
        edges = -1;
        while (edges < 0 && i < max_e) begin
            step();
            i++;
            if (rsp_valid) edges = i;
        end
    endtask

    task automatic serve(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input string tag);
        int e;
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid = 4'b0001 << id;
        #1;
        check({tag, "_ready"}, req_ready, 4'b0001 << id);
        step();
        req_valid = 4'b0000;
        check({tag, "_mul_en"}, mul_en, 1'b1);
        check({tag, "_mul_a"}, mul_a, a);
        check({tag, "_mul_b"}, mul_b, b);
        check({tag, "_busy"}, busy, 1'b1);
        wait_rsp(30, e);
        check({tag, "_lat"}, e, 11);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_prod"}, rsp_prod, exp_p);
        check({tag, "_err"}, rsp_err, 1'b0);
        step();
        check({tag, "_strobe_end"}, rsp_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int e;
        int cnt_v;
        logic [15:0] rr_prod [4];
        logic [7:0]  rr_a [4];
        logic [7:0]  rr_b [4];

        rst       = 1'b1;
        req_valid = 4'b0000;
        req_a     = 32'd0;
        req_b     = 32'd0;
        no_done   = 1'b0;
        step(); step(); step();
        check("rst_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mul_en", mul_en, 1'b0);
        check("rst_mul_a", mul_a, 8'd0);
        check("rst_mul_b", mul_b, 8'd0);
        check("rst_rsp", {rsp_id, rsp_prod, rsp_err}, 19'd0);
        rst = 1'b0;
        step();

        // Requester 0 wins first after reset; withdrawn before the edge, so no handshake.
        req_valid = 4'b1111;
        #1;
        check("first_win", req_ready, 4'b0001);
        req_valid = 4'b0000;

        serve(2, 8'd13, 8'd11, 16'd143, "single");
        serve(0, 8'd255, 8'd255, 16'd65025, "max");
        serve(1, 8'd0, 8'd200, 16'd0, "zero");
        serve(3, 8'd1, 8'd128, 16'd128, "one");

        // Round robin: last grant was 3, all held valid -> 0,1,2,3,0.
        rr_a[0] = 8'd3;   rr_b[0] = 8'd5;  rr_prod[0] = 16'd15;
        rr_a[1] = 8'd10;  rr_b[1] = 8'd20; rr_prod[1] = 16'd200;
        rr_a[2] = 8'd100; rr_b[2] = 8'd7;  rr_prod[2] = 16'd700;
        rr_a[3] = 8'd250; rr_b[3] = 8'd4;  rr_prod[3] = 16'd1000;
        for (int k = 0; k < 4; k++) begin
            req_a[8*k +: 8] = rr_a[k];
            req_b[8*k +: 8] = rr_b[k];
        end
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            cnt_v = 0;
            while (req_ready == 4'b0000 && cnt_v < 20) begin
                step();
                cnt_v++;
            end
            check("rr_grant", req_ready, 4'b0001 << (k % 4));
            step();
            if (k == 4) req_valid = 4'b0000;
            wait_rsp(30, e);
            check("rr_lat", e, 11);
            check("rr_id", rsp_id, k % 4);
            check("rr_prod", rsp_prod, rr_prod[k % 4]);
        end

        // Late request from 3 during WAIT; 1 raised and withdrawn while busy.
        step();
        req_a[7:0] = 8'd6;
        req_b[7:0] = 8'd7;
        req_valid  = 4'b0001;
        #1;
        check("late_ready0", req_ready, 4'b0001);
        step();
        req_valid = 4'b0000;
        step(); step(); step();
        req_a[31:24] = 8'd9;
        req_b[31:24] = 8'd9;
        req_a[15:8]  = 8'd50;
        req_b[15:8]  = 8'd50;
        req_valid    = 4'b1010;
        #1;
        check("busy_no_ready", req_ready, 4'b0000);
        step(); step();
        req_valid = 4'b1000;
        wait_rsp(30, e);
        check("late_lat0", e, 6);
        check("late_id0", rsp_id, 2'd0);
        check("late_prod0", rsp_prod, 16'd42);
        step();
        check("late_grant3", req_ready, 4'b1000);
        step();
        req_valid = 4'b0000;
        wait_rsp(30, e);
        check("late_lat3", e, 11);
        check("late_id3", rsp_id, 2'd3);
        check("late_prod3", rsp_prod, 16'd81);
        step();

        // Timeout: multiplier never signals done.
        no_done = 1'b1;
        req_a[23:16] = 8'd5;
        req_b[23:16] = 8'd5;
        req_valid    = 4'b0100;
        #1;
        check("tmo_ready", req_ready, 4'b0100);
        step();
        req_valid = 4'b0000;
        wait_rsp(40, e);
        check("tmo_lat", e, 16);
        check("tmo_err", rsp_err, 1'b1);
        check("tmo_prod", rsp_prod, 16'd0);
        check("tmo_id", rsp_id, 2'd2);
        step();
        check("tmo_idle", busy, 1'b0);
        check("tmo_strobe_end", rsp_valid, 1'b0);
        no_done = 1'b0;

        // Reset during WAIT aborts with no response.
        req_a[7:0] = 8'd2;
        req_b[7:0] = 8'd3;
        req_valid  = 4'b0001;
        step();
        req_valid = 4'b0000;
        step(); step(); step(); step();
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_mul", {mul_en, mul_a, mul_b}, 17'd0);
        check("mid_rst_rsp", {rsp_valid, rsp_id, rsp_prod, rsp_err}, 20'd0);
        check("mid_rst_ready", req_ready, 4'b0000);
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid) cnt_v++;
        end
        check("mid_no_rsp", cnt_v, 0);
        serve(1, 8'd12, 8'd12, 16'd144, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t, expected under 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
